// File: rtl/tow_pkg.sv
// Shared types and defaults for the push-button debounce/press detector.
// Holds the FSM state encoding and the default debounce/count widths.
// Pure declarations; no logic, no latency, no flow control.
package tow_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_HELD      = 2'd2,
        ST_DISARMING = 2'd3
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int COUNT_W_DEF         = 8;
    localparam int DB_CNT_W            = 16;

endpackage

// File: rtl/press_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
// Latency: count updates on the edge that samples inc/clr.
// Backpressure: none; inc beyond all-ones is absorbed.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? W'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/press_detector.sv
// Debounces a synchronized button level and emits press/release strobes plus a press count.
// Latency: pressed and strobes register on the edge of the DEBOUNCE_CYCLES-th consecutive sample.
// Backpressure: none; every sample is consumed on its edge.
module press_detector
    import tow_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int COUNT_W         = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sypush,
    input  logic               count_clr,
    output logic               pressed,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic [COUNT_W-1:0] press_count
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                pressed_q, pressed_d;
    logic                press_pulse_q, press_pulse_d;
    logic                release_pulse_q, release_pulse_d;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sypush) begin
                    state_d = ST_ARMING;
                    cnt_d   = DB_CNT_W'(1);
                end
            end
            ST_ARMING: begin
                if (!sypush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_HELD;
                    cnt_d         = '0;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DB_CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!sypush) begin
                    state_d = ST_DISARMING;
                    cnt_d   = DB_CNT_W'(1);
                end
            end
            ST_DISARMING: begin
                if (sypush) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = ST_IDLE;
                    cnt_d           = '0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DB_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // pressed tracks the next state so it moves on the same edge as the strobes
        pressed_d = (state_d == ST_HELD) || (state_d == ST_DISARMING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    sat_counter #(
        .W (COUNT_W)
    ) u_press_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (press_pulse_d),
        .clr   (count_clr),
        .count (press_count)
    );

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_press_detector.sv
// Bench for press_detector at DEBOUNCE_CYCLES=4, COUNT_W=8: directed scenarios plus a
// randomized run compared against a run-length reference model.
module tb_press_detector;

    localparam int D    = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          sypush;
    logic          count_clr;
    logic          pressed;
    logic          press_pulse;
    logic          release_pulse;
    logic [CW-1:0] press_count;

    int checks;
    int errors;

    // Reference model: stable level plus length of the current run of opposite samples.
    logic m_pressed;
    int   m_run;
    logic m_pp;
    logic m_rp;
    int   m_cnt;

    press_detector #(
        .DEBOUNCE_CYCLES (D),
        .COUNT_W         (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sypush        (sypush),
        .count_clr     (count_clr),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_count   (press_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_pressed = 1'b0;
        m_run     = 0;
        m_pp      = 1'b0;
        m_rp      = 1'b0;
        m_cnt     = 0;
    endtask

    task automatic model_edge(input logic s, input logic c);
        logic acc;
        acc  = 1'b0;
        m_pp = 1'b0;
        m_rp = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (s != m_pressed) begin
                m_run++;
                if (m_run == D) begin
                    m_pressed = s;
                    m_run     = 0;
                    if (s) begin
                        m_pp = 1'b1;
                        acc  = 1'b1;
                    end else begin
                        m_rp = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
            if (c) m_cnt = acc ? 1 : 0;
            else if (acc && m_cnt < CMAX) m_cnt++;
        end
    endtask

    // One clock: drive at negedge, model the rising edge, return 1 time unit after it.
    task automatic step(input logic s, input logic c, input logic r);
        @(negedge clk);
        sypush    = s;
        count_clr = c;
        rst       = r;
        @(posedge clk);
        model_edge(s, c);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sypush = 1'b0; count_clr = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        #2;
        checks++;
        if ({pressed, press_pulse, release_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async_flags: got %b expected 000", {pressed, press_pulse, release_pulse});
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_async_count: got %0d expected 0", press_count);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({pressed, press_pulse, release_pulse, press_count} !== 11'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0", {pressed, press_pulse, release_pulse, press_count});
        end
    endtask

    task automatic test_clean_press();
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (press_pulse !== (i == D)) begin
                errors++;
                $display("FAIL clean_press_pulse cyc %0d: got %b expected %b", i, press_pulse, (i == D));
            end
            checks++;
            if (pressed !== (i >= D)) begin
                errors++;
                $display("FAIL clean_pressed cyc %0d: got %b expected %b", i, pressed, (i >= D));
            end
            checks++;
            if (press_count !== ((i >= D) ? 8'd1 : 8'd0)) begin
                errors++;
                $display("FAIL clean_count cyc %0d: got %0d expected %0d", i, press_count, (i >= D) ? 1 : 0);
            end
        end
    endtask

    task automatic test_release();
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (release_pulse !== (i == D) || press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL release_pulse cyc %0d: got rp=%b pp=%b expected rp=%b pp=0", i, release_pulse, press_pulse, (i == D));
            end
            checks++;
            if (pressed !== (i < D)) begin
                errors++;
                $display("FAIL release_pressed cyc %0d: got %b expected %b", i, pressed, (i < D));
            end
        end
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0);
        // two-sample low glitch inside HELD
        for (int i = 1; i <= 8; i++) begin
            step((i > 2), 1'b0, 1'b0);
            checks++;
            if (release_pulse !== 1'b0 || pressed !== 1'b1) begin
                errors++;
                $display("FAIL held_glitch cyc %0d: got rp=%b pressed=%b expected rp=0 pressed=1", i, release_pulse, pressed);
            end
        end
        for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (press_count !== 8'd2 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL release_end: got count=%0d pressed=%b expected count=2 pressed=0", press_count, pressed);
        end
    endtask

    task automatic test_glitch();
        for (int i = 1; i <= 8; i++) begin
            step((i <= D - 1), 1'b0, 1'b0);
            checks++;
            if (press_pulse !== 1'b0 || pressed !== 1'b0 || press_count !== 8'd2) begin
                errors++;
                $display("FAIL glitch cyc %0d: got pp=%b pressed=%b count=%0d expected 0 0 2", i, press_pulse, pressed, press_count);
            end
        end
        // back in IDLE: a fresh press needs exactly D samples
        for (int i = 1; i <= D; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (press_pulse !== (i == D)) begin
                errors++;
                $display("FAIL glitch_recover cyc %0d: got %b expected %b", i, press_pulse, (i == D));
            end
        end
        for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (press_count !== 8'd3) begin
            errors++;
            $display("FAIL glitch_count: got %0d expected 3", press_count);
        end
    endtask

    task automatic test_saturation_clear();
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL clear_only: got %0d expected 0", press_count);
        end
        for (int k = 1; k <= 257; k++) begin
            for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0);
            checks++;
            if (int'(press_count) !== ((k > CMAX) ? CMAX : k)) begin
                errors++;
                $display("FAIL sat_count press %0d: got %0d expected %0d", k, press_count, (k > CMAX) ? CMAX : k);
            end
            for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b0);
        end
        for (int i = 1; i < D; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (press_count !== 8'd1 || press_pulse !== 1'b1) begin
            errors++;
            $display("FAIL clear_with_press: got count=%0d pp=%b expected count=1 pp=1", press_count, press_pulse);
        end
        for (int i = 0; i < D; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({pressed, press_pulse, release_pulse, press_count} !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid_arming: got %b expected 0", {pressed, press_pulse, release_pulse, press_count});
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1);
            checks++;
            if ({pressed, press_pulse, release_pulse, press_count} !== 11'd0) begin
                errors++;
                $display("FAIL rst_held cyc %0d: got %b expected 0", i, {pressed, press_pulse, release_pulse, press_count});
            end
        end
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if (press_pulse !== (i == D) || pressed !== (i >= D)) begin
                errors++;
                $display("FAIL post_rst_press cyc %0d: got pp=%b pressed=%b expected pp=%b pressed=%b", i, press_pulse, pressed, (i == D), (i >= D));
            end
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (pressed !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_disarming: got pressed=%b count=%0d expected 0 0", pressed, press_count);
        end
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (release_pulse !== 1'b0 || pressed !== 1'b0) begin
                errors++;
                $display("FAIL post_rst_release cyc %0d: got rp=%b pressed=%b expected 0 0", i, release_pulse, pressed);
            end
        end
    endtask

    task automatic test_random();
        logic s;
        int   hold;
        s    = 1'b0;
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                s    = ~s;
                hold = $urandom_range(1, 2 * D);
            end
            hold--;
            step(s, ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) == 0));
            checks++;
            if (pressed !== m_pressed || press_pulse !== m_pp || release_pulse !== m_rp) begin
                errors++;
                $display("FAIL rand_flags cyc %0d: got %b%b%b expected %b%b%b", n, pressed, press_pulse, release_pulse, m_pressed, m_pp, m_rp);
            end
            checks++;
            if (int'(press_count) !== m_cnt) begin
                errors++;
                $display("FAIL rand_count cyc %0d: got %0d expected %0d", n, press_count, m_cnt);
            end
            checks++;
            if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
                errors++;
                $display("FAIL rand_exclusive cyc %0d: got both pulses high expected at most one", n);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clean_press();
        test_release();
        test_glitch();
        test_saturation_clear();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/press_detector.md
PRESS_DETECTOR -- requirements
Module: press_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive equal samples needed to accept a level change; legal range 2..65535.
REQ-002 Parameter COUNT_W, default 8: width of press_count.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port sypush  input  1  button level, already synchronized to clk; 1 = pressed.
REQ-006 Port count_clr  input  1  synchronous clear of press_count.
REQ-007 Port pressed  output  1  debounced button level, registered.
REQ-008 Port press_pulse  output  1  one-cycle strobe on each accepted press, registered.
REQ-009 Port release_pulse  output  1  one-cycle strobe on each accepted release, registered.
REQ-010 Port press_count  output  COUNT_W  number of accepted presses since reset or clear; saturating.

Function
REQ-011 The block SHALL implement a 4-state FSM: IDLE (stable released), ARMING (press candidate), HELD (stable pressed), DISARMING (release candidate).
REQ-012 The block SHALL use one debounce counter, 16 bits wide, counting consecutive samples in ARMING/DISARMING.
REQ-013 IDLE: sypush=1 -> ARMING with counter=1; sypush=0 -> stay.
REQ-014 ARMING: sypush=0 -> IDLE, counter=0; sypush=1 and counter<DEBOUNCE_CYCLES-1 -> counter+1; sypush=1 and counter=DEBOUNCE_CYCLES-1 -> HELD, counter=0.
REQ-015 HELD/DISARMING SHALL mirror REQ-013/014 with sypush inverted: HELD->DISARMING on sypush=0; DISARMING->HELD on sypush=1; DISARMING->IDLE after DEBOUNCE_CYCLES consecutive 0 samples.
REQ-016 press_pulse SHALL be 1 for exactly the one cycle following the edge of the ARMING->HELD transition, i.e. after DEBOUNCE_CYCLES consecutive high samples; 0 otherwise.
REQ-017 release_pulse SHALL be 1 for exactly the one cycle following the edge of the DISARMING->IDLE transition; 0 otherwise.
REQ-018 pressed SHALL be 1 when the state is HELD or DISARMING, changing on the same edge as the corresponding pulse.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES samples SHALL return the FSM to its prior stable state with no pulse and no change of pressed.
REQ-020 press_count SHALL increment by 1 on the edge that raises press_pulse and saturate at 2^COUNT_W-1.
REQ-021 count_clr=1 SHALL set press_count to 0 on the next edge; if a press is accepted on the same edge, press_count SHALL become 1.
REQ-022 press_pulse and release_pulse SHALL never be 1 in the same cycle.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, debounce counter 0, pressed 0, press_pulse 0, release_pulse 0, press_count 0, independent of clk.
REQ-024 If sypush is high when rst deasserts, a press SHALL be accepted only after DEBOUNCE_CYCLES fresh high samples; no pulse SHALL be generated by reset release itself.
REQ-025 Reset asserted mid-ARMING or mid-DISARMING SHALL discard the partial count and emit no pulse.

Structure
REQ-026 The shared package tow_pkg SHALL hold the FSM state encoding, the default DEBOUNCE_CYCLES, and the default COUNT_W.
REQ-027 The saturating press counter SHALL be a separate sub-module sat_counter (inc, clr, count, saturating at all-ones); the FSM and debounce counter stay in press_detector.

Verification (DEBOUNCE_CYCLES=4, COUNT_W=8)
REQ-028 Clean press: sypush 0->1 held 10 cycles -> press_pulse high exactly 1 cycle, after the 4th high sample; pressed=1 from that cycle; press_count=1.
REQ-029 Glitch: sypush high 3 cycles, then 0 -> no press_pulse; pressed stays 0; press_count stays 0; FSM back in IDLE.
REQ-030 Release: from HELD, sypush 1->0 held 10 cycles -> release_pulse high 1 cycle after the 4th low sample; pressed=0 on that same edge; a 2-cycle low glitch inside HELD produces no release_pulse.
REQ-031 Saturation and clear: 257 accepted presses -> press_count=255; then count_clr pulsed on the acceptance edge of the next press -> press_count=1.
REQ-032 Reset mid-operation: rst asserted during ARMING with sypush held high, then released -> all outputs 0 during reset; press_pulse appears exactly after 4 post-reset high samples.
